// File: rtl/data_mem_if_if.sv
// Split-handshake SRAM-like data bus between the MEM-stage access unit and memory.
// The unit drives requests as master; the memory answers with addr_ok/data_ok.
interface data_mem_if_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [3:0]    data_wstrb;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic [DW-1:0] data_rdata;
  logic          data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok
  );
endinterface

// File: rtl/data_mem_if.sv
// MEM-stage data access unit: store narrowing/strobes, load extraction/extension,
// and a split-handshake bus FSM that stalls the pipeline while an access is in flight.
module data_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_en,
  input  logic [2:0]    mem_op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  output logic          stall,
  output logic [DW-1:0] rdata_out,
  output logic          adel,
  output logic          ades,
  data_mem_if_if.master bus
);
  localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3,
                         OP_LW = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic          cancel;
  logic [2:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    wstrb_q;
  logic [1:0]    size_q;
  logic          wr_q;

  logic          issue;
  logic [DW-1:0] st_data;
  logic [3:0]    st_strb;
  logic [1:0]    st_size;
  logic          st_wr;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [DW-1:0] ld_data;

  // Alignment faults only matter for an actual memory instruction.
  always_comb begin
    adel = 1'b0;
    ades = 1'b0;
    if (mem_en) begin
      case (mem_op)
        OP_LH, OP_LHU: adel = addr[0];
        OP_LW:         adel = |addr[1:0];
        OP_SH:         ades = addr[0];
        OP_SW:         ades = |addr[1:0];
        default: ;
      endcase
    end
  end

  assign issue = mem_en & ~flush & ~adel & ~ades & ~rst;
  assign stall = ((state == IDLE) & issue) | (state == REQ) | (state == WAIT);

  always_comb begin
    st_data = '0;
    st_strb = 4'b0000;
    st_size = 2'd2;
    st_wr   = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU: st_size = 2'd0;
      OP_LH, OP_LHU: st_size = 2'd1;
      OP_SB: begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << addr[1:0];
        st_size = 2'd0;
        st_wr   = 1'b1;
      end
      OP_SH: begin
        st_data = {2{wdata[15:0]}};
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
        st_size = 2'd1;
        st_wr   = 1'b1;
      end
      OP_SW: begin
        st_data = wdata;
        st_strb = 4'b1111;
        st_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = bus.data_rdata[7:0];
      2'd1:    lane_b = bus.data_rdata[15:8];
      2'd2:    lane_b = bus.data_rdata[23:16];
      default: lane_b = bus.data_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (op_q)
      OP_LB:   ld_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_data = {24'd0, lane_b};
      OP_LH:   ld_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_data = {16'd0, lane_h};
      default: ld_data = bus.data_rdata;
    endcase
  end

  assign bus.data_req   = (state == REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wstrb = wstrb_q;
  assign bus.data_wdata = wdata_q;

  // A flushed access still finishes on the bus, but returns straight to IDLE
  // without a DONE cycle and without touching rdata_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cancel    <= 1'b0;
      op_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      size_q    <= 2'd0;
      wr_q      <= 1'b0;
      rdata_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (issue) begin
            op_q    <= mem_op;
            addr_q  <= addr;
            wdata_q <= st_data;
            wstrb_q <= st_strb;
            size_q  <= st_size;
            wr_q    <= st_wr;
            state   <= REQ;
          end
        end
        REQ: begin
          if (flush) cancel <= 1'b1;
          if (bus.data_addr_ok) begin
            if (!bus.data_data_ok) begin
              state <= WAIT;
            end else if (cancel | flush) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              if (!wr_q) rdata_out <= ld_data;
            end
          end
        end
        WAIT: begin
          if (flush) cancel <= 1'b1;
          if (bus.data_data_ok) begin
            if (cancel | flush) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              if (!wr_q) rdata_out <= ld_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_if.sv
// Directed bench for data_mem_if: store formatting, load extension, alignment
// faults, delayed handshakes, flush cancellation and mid-transaction reset.
module tb_data_mem_if;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic [2:0]  mem_op = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic        stall, adel, ades;
  logic [31:0] rdata_out;
  int checks = 0;
  int errors = 0;

  data_mem_if_if #(.AW(32), .DW(32)) bus ();

  data_mem_if #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .flush(flush), .stall(stall), .rdata_out(rdata_out),
    .adel(adel), .ades(ades), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_in(input logic aok, input logic dok, input logic [31:0] rd);
    bus.data_addr_ok = aok;
    bus.data_data_ok = dok;
    bus.data_rdata   = rd;
  endtask

  task automatic instr(input logic en, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    mem_en = en;
    mem_op = op;
    addr   = a;
    wdata  = wd;
  endtask

  initial begin
    bus_in(1'b0, 1'b0, 32'h0);
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, bus.data_req}, 32'd0);
    chk("rst_wr", {31'd0, bus.data_wr}, 32'd0);
    chk("rst_wstrb", {28'd0, bus.data_wstrb}, 32'd0);
    chk("rst_rdata_out", rdata_out, 32'd0);
    chk("rst_addr", bus.data_addr, 32'd0);
    chk("rst_wdata", bus.data_wdata, 32'd0);
    chk("rst_adel_ades", {30'd0, adel, ades}, 32'd0);
    cyc();
    rst = 1'b0;

    // SB with zero-wait bus
    cyc();
    instr(1'b1, 3'd5, 32'h1002, 32'hAABBCCDD); #1;
    chk("sb_issue_stall", {31'd0, stall}, 32'd1);
    chk("sb_issue_req", {31'd0, bus.data_req}, 32'd0);
    cyc();
    bus_in(1'b1, 1'b1, 32'h0); #1;
    chk("sb_req", {31'd0, bus.data_req}, 32'd1);
    chk("sb_stall2", {31'd0, stall}, 32'd1);
    chk("sb_wdata", bus.data_wdata, 32'hDDDDDDDD);
    chk("sb_wstrb", {28'd0, bus.data_wstrb}, 32'h4);
    chk("sb_size", {30'd0, bus.data_size}, 32'd0);
    chk("sb_wr", {31'd0, bus.data_wr}, 32'd1);
    chk("sb_addr", bus.data_addr, 32'h1002);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("sb_done_stall", {31'd0, stall}, 32'd0);
    chk("sb_done_req", {31'd0, bus.data_req}, 32'd0);

    // SH upper half
    cyc();
    instr(1'b1, 3'd6, 32'h1002, 32'h00001234); #1;
    chk("sh_issue_stall", {31'd0, stall}, 32'd1);
    cyc();
    bus_in(1'b1, 1'b1, 32'h0); #1;
    chk("sh_wdata", bus.data_wdata, 32'h12341234);
    chk("sh_wstrb", {28'd0, bus.data_wstrb}, 32'hC);
    chk("sh_size", {30'd0, bus.data_size}, 32'd1);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("sh_done_stall", {31'd0, stall}, 32'd0);

    // LB, byte 3 negative
    cyc();
    instr(1'b1, 3'd0, 32'h2003, 32'h0); #1;
    chk("lb_no_fault", {30'd0, adel, ades}, 32'd0);
    cyc();
    bus_in(1'b1, 1'b1, 32'h80FF7F01); #1;
    chk("lb_wr", {31'd0, bus.data_wr}, 32'd0);
    chk("lb_wstrb", {28'd0, bus.data_wstrb}, 32'd0);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("lb_rdata", rdata_out, 32'hFFFFFF80);
    chk("lb_done_stall", {31'd0, stall}, 32'd0);

    // LBU same lane
    cyc();
    instr(1'b1, 3'd1, 32'h2003, 32'h0);
    cyc();
    bus_in(1'b1, 1'b1, 32'h80FF7F01);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("lbu_rdata", rdata_out, 32'h00000080);

    // LH with delayed handshake; a stray data_ok in REQ must be ignored
    cyc();
    instr(1'b1, 3'd2, 32'h2002, 32'h0); #1;
    chk("lh_issue_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus_in(1'b0, (i == 1), 32'h8001FFFF); #1;
      chk("lh_req_wait_stall", {31'd0, stall}, 32'd1);
      chk("lh_req_held", {31'd0, bus.data_req}, 32'd1);
    end
    cyc();
    bus_in(1'b1, 1'b0, 32'h8001FFFF); #1;
    chk("lh_aok_req", {31'd0, bus.data_req}, 32'd1);
    cyc();
    bus_in(1'b0, 1'b0, 32'h8001FFFF); #1;
    chk("lh_wait_req", {31'd0, bus.data_req}, 32'd0);
    chk("lh_wait_stall", {31'd0, stall}, 32'd1);
    chk("lh_wait_rdata_hold", rdata_out, 32'h00000080);
    cyc();
    bus_in(1'b0, 1'b1, 32'h8001FFFF); #1;
    chk("lh_dok_stall", {31'd0, stall}, 32'd1);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("lh_rdata", rdata_out, 32'hFFFF8001);
    chk("lh_done_stall", {31'd0, stall}, 32'd0);

    // Misaligned LW / SW
    cyc();
    instr(1'b1, 3'd4, 32'h3001, 32'h0); #1;
    chk("lw_adel", {30'd0, adel, ades}, 32'd2);
    chk("lw_adel_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("lw_adel_noreq", {31'd0, bus.data_req}, 32'd0);
    instr(1'b1, 3'd7, 32'h3006, 32'h55); #1;
    chk("sw_ades", {30'd0, adel, ades}, 32'd1);
    chk("sw_ades_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("sw_ades_noreq", {31'd0, bus.data_req}, 32'd0);

    // LW flushed during WAIT
    instr(1'b1, 3'd4, 32'h4000, 32'h0);
    cyc();
    bus_in(1'b1, 1'b0, 32'h0);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    mem_en = 1'b0; #1;
    chk("fl_wait_stall", {31'd0, stall}, 32'd1);
    cyc();
    flush = 1'b0;
    bus_in(1'b0, 1'b1, 32'h12345678); #1;
    chk("fl_dok_stall", {31'd0, stall}, 32'd1);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0);
    // A fresh issue raising stall proves the FSM is in IDLE, not DONE
    instr(1'b1, 3'd4, 32'h4004, 32'h0); #1;
    chk("fl_idle_issue_stall", {31'd0, stall}, 32'd1);
    chk("fl_rdata_kept", rdata_out, 32'hFFFF8001);

    // Reset while in WAIT
    cyc();
    bus_in(1'b1, 1'b0, 32'h0);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("rw_wait_req", {31'd0, bus.data_req}, 32'd0);
    chk("rw_wait_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1; #1;
    chk("rw_rst_stall", {31'd0, stall}, 32'd0);
    chk("rw_rst_req", {31'd0, bus.data_req}, 32'd0);
    chk("rw_rst_rdata", rdata_out, 32'd0);
    cyc();
    rst = 1'b0;
    mem_en = 1'b0;
    bus_in(1'b0, 1'b1, 32'hDEADBEEF);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("rw_stray_dok_idle", {30'd0, stall, bus.data_req}, 32'd0);

    // Normal access after reset
    instr(1'b1, 3'd4, 32'h5004, 32'h0); #1;
    chk("post_issue_stall", {31'd0, stall}, 32'd1);
    cyc();
    bus_in(1'b1, 1'b1, 32'hCAFEBABE); #1;
    chk("post_addr", bus.data_addr, 32'h5004);
    chk("post_size", {30'd0, bus.data_size}, 32'd2);
    cyc();
    bus_in(1'b0, 1'b0, 32'h0); #1;
    chk("post_rdata", rdata_out, 32'hCAFEBABE);
    chk("post_done_stall", {31'd0, stall}, 32'd0);
    cyc();
    mem_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_if.md
Name: data_mem_if

Overview:
- Data-side memory access unit for the 57-instruction MIPS core, instantiated in the MEM stage.
- Store direction:
  - narrows register data to byte/halfword/word;
  - replicates it across byte lanes;
  - generates write strobes.
- Load direction: extracts the addressed lane and sign- or zero-extends it to 32 bits.
- Drives an SRAM-like split-handshake data bus (req/addr_ok, data_ok) and stalls the pipeline while a transaction is outstanding.

Parameters:
- AW, 32, address width (bits).
- DW, 32, data width (fixed at 32; lane logic assumes 4 bytes).

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_en  input  1  MEM-stage instruction is a load/store.
- mem_op  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- addr  input  AW  effective address.
- wdata  input  32  store source register value.
- flush  input  1  exception/flush of the MEM-stage instruction.
- stall  output  1  holds the pipeline.
- rdata_out  output  32  extended load result.
- adel  output  1  load address error.
- ades  output  1  store address error.
- data_req  output  1  bus request.
- data_wr  output  1  1 = write.
- data_size  output  2  0 byte, 1 half, 2 word.
- data_addr  output  AW  bus address.
- data_wstrb  output  4  byte write strobes.
- data_wdata  output  32  lane-replicated store data.
- data_addr_ok  input  1  request accepted.
- data_rdata  input  32  read data.
- data_data_ok  input  1  data phase complete.

Behaviour:
- Reset (async, rst=1):
  - state IDLE, cancel flag cleared.
  - data_req, data_wr, data_wstrb, stall, adel, ades all 0.
  - rdata_out, data_addr, data_wdata all 0.
- Alignment check (combinational, from addr and mem_op):
  - LH/LHU with addr[0]=1 -> adel=1.
  - LW with addr[1:0]!=0 -> adel=1.
  - SH with addr[0]=1 -> ades=1.
  - SW with addr[1:0]!=0 -> ades=1.
  - Byte ops never fault.
  - A faulting access issues no request and never stalls.
- Issue condition: "issue" = mem_en & ~flush & ~adel & ~ades, evaluated in IDLE.
- FSM states IDLE, REQ, WAIT, DONE.
  - IDLE:
    - On issue, latch op, addr, formatted wdata and wstrb; go to REQ.
    - stall=1 combinationally in the issue cycle.
  - REQ:
    - data_req=1 with latched fields held stable.
    - addr_ok=0 -> stay in REQ.
    - addr_ok=1, data_ok=0 -> WAIT.
    - addr_ok=1, data_ok=1 in the same cycle -> DONE.
  - WAIT:
    - data_req=0.
    - On data_ok -> DONE, latching the formatted load result into rdata_out.
    - Loads latch rdata_out; stores leave rdata_out unchanged.
  - DONE:
    - stall=0 for exactly one cycle, so the pipeline advances on this edge.
    - Go to IDLE unconditionally.
  - stall=1 in REQ and WAIT.
- Minimum access latency: issue cycle, then 1 REQ cycle, then DONE = 2 stall cycles with zero-wait addr_ok+data_ok.
- Store formatting (narrowing):
  - SB: data_wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0], size 0.
  - SH: data_wdata={2{wdata[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011, size 1.
  - SW: data_wdata=wdata, wstrb=4'b1111, size 2.
  - Loads: data_wr=0, wstrb=0000.
- data_addr = latched full addr; no forced alignment.
- Load extraction:
  - Byte lane selected by addr[1:0]; halfword by addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LW passes data_rdata through unchanged.
- Flush in REQ or WAIT:
  - Sets cancel flag; the bus transaction still completes (req held until addr_ok).
  - On data_ok, go directly to IDLE, skipping DONE.
  - rdata_out is not updated; stall stays 1 until then.
- data_ok received while in REQ without addr_ok, or in IDLE: ignored.
- rst asserted mid-transaction: immediate return to IDLE; any in-flight bus response is dropped.

Test Plan:
- SB, addr=0x1002, wdata=0xAABBCCDD, addr_ok and data_ok in the cycle after req:
  - data_wdata=0xDDDDDDDD, wstrb=0100, size=0, data_wr=1.
  - stall high 2 cycles, then low 1 cycle.
- SH, addr=0x1002, wdata=0x00001234 -> data_wdata=0x12341234, wstrb=1100, size=1.
- LB addr=0x2003 and LBU addr=0x2003, with data_rdata=0x80FF7F01:
  - LB -> rdata_out=0xFFFFFF80.
  - LBU -> rdata_out=0x00000080.
- LH addr=0x2002, data_rdata=0x8001FFFF, addr_ok delayed 3 cycles, data_ok 2 cycles after that:
  - rdata_out=0xFFFF8001.
  - stall high from issue cycle through the data_ok cycle.
- LW addr=0x3001 -> adel=1, data_req never asserted, stall=0.
- SW addr=0x3006 -> ades=1, data_req never asserted, stall=0.
- LW issued, flush pulsed during WAIT, data_ok=1 with data_rdata=0x12345678:
  - FSM returns to IDLE without DONE.
  - rdata_out keeps its previous value.
- rst asserted while in WAIT:
  - data_req=0 and stall=0 immediately.
  - FSM in IDLE; next access completes normally.
